register_file_sb: RTL

REGISTER_FILE_SB -- requirements
Module: register_file_sb

---
 rtl/register_file_sb_if.sv | 33 +++
 rtl/register_file_sb.sv | 110 +++++++++++
 2 files changed

// File: rtl/register_file_sb_if.sv
// Bus bundle for register_file_sb: two read ports, two write ports, issue port and pending count.
interface register_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] RdAddr1;
  logic [ADDR_W-1:0] RdAddr2;
  logic [DATA_W-1:0] RdData1;
  logic [DATA_W-1:0] RdData2;
  logic              RdPend1;
  logic              RdPend2;
  logic              WrEnA;
  logic              WrEnB;
  logic [ADDR_W-1:0] WrAddrA;
  logic [ADDR_W-1:0] WrAddrB;
  logic [DATA_W-1:0] WrDataA;
  logic [DATA_W-1:0] WrDataB;
  logic              IssueEn;
  logic [ADDR_W-1:0] IssueAddr;
  logic [ADDR_W:0]   PendCount;

  modport master (
    output RdAddr1, RdAddr2, WrEnA, WrEnB, WrAddrA, WrAddrB, WrDataA, WrDataB,
           IssueEn, IssueAddr,
    input  RdData1, RdData2, RdPend1, RdPend2, PendCount
  );

  modport slave (
    input  RdAddr1, RdAddr2, WrEnA, WrEnB, WrAddrA, WrAddrB, WrDataA, WrDataB,
           IssueEn, IssueAddr,
    output RdData1, RdData2, RdPend1, RdPend2, PendCount
  );
endinterface

// File: rtl/register_file_sb.sv
// Dual-write, dual-read register file with a per-register pending (scoreboard) bit
// and an incrementally maintained count of pending registers.
module register_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic clk,
  input logic rst_n,
  register_file_sb_if.slave rf
);
  localparam int DEPTH  = 2**ADDR_W;
  localparam bit ZeroEn = (ZERO_REG != 0);
  localparam bit BypEn  = (BYPASS != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pendNext;
  logic [ADDR_W:0]   pendCount;
  logic [ADDR_W:0]   pendCountNext;

  logic wrValidA;
  logic wrValidB;
  logic issueValid;
  logic newSet;
  logic clrA;
  logic clrB;

  // Register 0 is hard-wired when ZeroEn, so its writes and issues never qualify.
  assign wrValidA   = rf.WrEnA   && !(ZeroEn && (rf.WrAddrA   == '0));
  assign wrValidB   = rf.WrEnB   && !(ZeroEn && (rf.WrAddrB   == '0));
  assign issueValid = rf.IssueEn && !(ZeroEn && (rf.IssueAddr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wrValidA) mem[rf.WrAddrA] <= rf.WrDataA;
      if (wrValidB) mem[rf.WrAddrB] <= rf.WrDataB;
    end
  end

  // Issue is applied after the clears so a same-cycle issue leaves the bit set.
  always_comb begin
    pendNext = pend;
    if (wrValidA)   pendNext[rf.WrAddrA]   = 1'b0;
    if (wrValidB)   pendNext[rf.WrAddrB]   = 1'b0;
    if (issueValid) pendNext[rf.IssueAddr] = 1'b1;
  end

  // Count each real 0->1 and 1->0 transition once; port B skips an address port A already cleared.
  always_comb begin
    newSet = issueValid && !pend[rf.IssueAddr];
    clrA   = wrValidA && pend[rf.WrAddrA]
             && !(issueValid && (rf.IssueAddr == rf.WrAddrA));
    clrB   = wrValidB && pend[rf.WrAddrB]
             && !(issueValid && (rf.IssueAddr == rf.WrAddrB))
             && !(wrValidA && (rf.WrAddrA == rf.WrAddrB));
    pendCountNext = pendCount
                    + {{ADDR_W{1'b0}}, newSet}
                    - {{ADDR_W{1'b0}}, clrA}
                    - {{ADDR_W{1'b0}}, clrB};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      pendCount <= '0;
    end else begin
      pend      <= pendNext;
      pendCount <= pendCountNext;
    end
  end

  function automatic logic [DATA_W:0] readPort(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              storedPend
  );
    logic issueHit;
    issueHit = rf.IssueEn && (rf.IssueAddr == addr);
    if (ZeroEn && (addr == '0))
      return '0;
    else if (BypEn && wrValidB && (rf.WrAddrB == addr))
      return {issueHit, rf.WrDataB};
    else if (BypEn && wrValidA && (rf.WrAddrA == addr))
      return {issueHit, rf.WrDataA};
    else
      return {storedPend, stored};
  endfunction

  logic [DATA_W:0] rd1;
  logic [DATA_W:0] rd2;

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rst_n) begin
      rd1 = readPort(rf.RdAddr1, mem[rf.RdAddr1], pend[rf.RdAddr1]);
      rd2 = readPort(rf.RdAddr2, mem[rf.RdAddr2], pend[rf.RdAddr2]);
    end
  end

  assign rf.RdData1   = rd1[DATA_W-1:0];
  assign rf.RdPend1   = rd1[DATA_W];
  assign rf.RdData2   = rd2[DATA_W-1:0];
  assign rf.RdPend2   = rd2[DATA_W];
  assign rf.PendCount = pendCount;
endmodule
